// File: rtl/xpmwrap_pkg.sv
// rtl/xpmwrap_pkg.sv - shared types and constants for the arbitrated distributed-RAM wrapper
package xpmwrap_pkg;

   localparam int RAM_READ_LATENCY = 2;
   // one stage for the command register plus the RAM read latency
   localparam int TAG_STAGES       = RAM_READ_LATENCY + 1;
   // requester id width sized for the largest legal requester count (4)
   localparam int ID_W             = 2;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/xpmwrap_rr_arb.sv
// rtl/xpmwrap_rr_arb.sv - round-robin grant generator with rotating priority pointer
module xpmwrap_rr_arb
   import xpmwrap_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   logic [ID_W-1:0] ptr;

   // grant the first requester at or after ptr, searching cyclically
   always_comb begin
      int idx;
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (en && !grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end

   // move priority to the requester after the one just served; hold when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/xpmwrap_dpdistram_arb.sv
// rtl/xpmwrap_dpdistram_arb.sv - multi-requester arbiter in front of a latency-2 RAM port
module xpmwrap_dpdistram_arb
   import xpmwrap_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int ADDR_WIDTH    = 6,
   parameter int DATA_WIDTH    = 32,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          init_done,
   output logic                          busy,
   output logic                          ram_ena,
   output logic                          ram_wea,
   output logic [ADDR_WIDTH-1:0]         ram_addra,
   output logic [DATA_WIDTH-1:0]         ram_dina,
   output logic                          ram_regcea,
   output logic                          ram_rsta,
   input  logic [DATA_WIDTH-1:0]         ram_douta
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                  init_done_q;

   logic                  arb_en;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       grant_id;
   logic                  grant_any;

   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic                  issue_valid, issue_we;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [DATA_WIDTH-1:0] issue_data;

   logic                  cmd_valid_q, cmd_we_q;
   logic [ADDR_WIDTH-1:0] cmd_addr_q;
   logic [DATA_WIDTH-1:0] cmd_data_q;

   tag_t                  tag_q [TAG_STAGES];

   // requesters are only served once the zero-fill has finished
   assign arb_en = (state_q == ST_RUN) && init_done_q;

   xpmwrap_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .en        (arb_en),
      .req       (req_valid),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   assign req_ready = grant;

   // pick the granted requester's command fields out of the packed buses
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // next state and the command presented to the command register
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      issue_valid = 1'b0;
      issue_we    = 1'b0;
      issue_addr  = '0;
      issue_data  = '0;
      case (state_q)
         ST_INIT: begin
            issue_valid = 1'b1;
            issue_we    = 1'b1;
            issue_addr  = init_cnt_q;
            init_cnt_d  = init_cnt_q + 1'b1;
            if (&init_cnt_q) state_d = ST_RUN;
         end
         ST_RUN: begin
            issue_valid = grant_any;
            issue_we    = sel_we;
            issue_addr  = sel_addr;
            issue_data  = sel_wdata;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // FSM state, zero-fill address counter and run flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= (state_d == ST_RUN);
      end
   end

   // command register driving RAM port A one cycle after acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_valid_q <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
      end else begin
         cmd_valid_q <= issue_valid;
         cmd_we_q    <= issue_we;
         cmd_addr_q  <= issue_addr;
         cmd_data_q  <= issue_data;
      end
   end

   // read tags travel alongside the command register and RAM latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TAG_STAGES; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: issue_valid && !issue_we, id: grant_id};
         for (int i = 1; i < TAG_STAGES; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign ram_ena    = cmd_valid_q;
   assign ram_wea    = cmd_we_q;
   assign ram_addra  = cmd_addr_q;
   assign ram_dina   = cmd_data_q;
   assign ram_regcea = 1'b1;
   assign ram_rsta   = rst;
   assign init_done  = init_done_q;

   // steer RAM output to the requester named by the last tag stage
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (tag_q[TAG_STAGES-1].valid) begin
         rsp_rdata = ram_douta;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_q[TAG_STAGES-1].id == ID_W'(i)) rsp_valid[i] = 1'b1;
         end
      end
   end

   // anything outstanding, or still zero-filling
   always_comb begin
      busy = cmd_valid_q || (state_q == ST_INIT);
      for (int i = 0; i < TAG_STAGES; i++) busy = busy || tag_q[i].valid;
   end

endmodule

// File: tb/tb_xpmwrap_dpdistram_arb.sv
// tb/tb_xpmwrap_dpdistram_arb.sv - self-checking bench for the arbitrated RAM wrapper
module tb_xpmwrap_dpdistram_arb;

   localparam int NUM_REQ  = 2;
   localparam int AW       = 6;
   localparam int DW       = 32;
   localparam int DEPTH    = 1 << AW;
   localparam int INIT_LEN = DEPTH;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NUM_REQ-1:0]    req_valid = '0;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ-1:0]    req_we = '0;
   logic [NUM_REQ*AW-1:0] req_addr = '0;
   logic [NUM_REQ*DW-1:0] req_wdata = '0;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [DW-1:0]         rsp_rdata;
   logic                  init_done, busy;
   logic                  ram_ena, ram_wea, ram_regcea, ram_rsta;
   logic [AW-1:0]         ram_addra;
   logic [DW-1:0]         ram_dina;
   logic [DW-1:0]         ram_douta;

   always #5 clk = ~clk;

   xpmwrap_dpdistram_arb #(
      .NUM_REQ       (NUM_REQ),
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .INIT_ON_RESET (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .init_done  (init_done),
      .busy       (busy),
      .ram_ena    (ram_ena),
      .ram_wea    (ram_wea),
      .ram_addra  (ram_addra),
      .ram_dina   (ram_dina),
      .ram_regcea (ram_regcea),
      .ram_rsta   (ram_rsta),
      .ram_douta  (ram_douta)
   );

   // RAM with two-cycle read latency; contents seeded with garbage
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] ram_s1;
   logic          mem_seeded = 1'b0;
   always @(posedge clk) begin
      if (!mem_seeded) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom | 32'h1;
         mem_seeded <= 1'b1;
      end else if (ram_ena) begin
         if (ram_wea) mem[ram_addra] <= ram_dina;
      end
      if (ram_ena) ram_s1 <= mem[ram_addra];
      if (ram_rsta) ram_douta <= '0;
      else if (ram_regcea) ram_douta <= ram_s1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: per-cycle history of issued commands and due responses
   typedef struct {
      logic          v;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_rec_t;

   cmd_rec_t      ring [8];
   logic          rd_ring [8];
   logic          pend_v [8];
   int            pend_id [8];
   logic [DW-1:0] pend_d [8];
   logic [DW-1:0] shadow [DEPTH];
   int            m_cyc = 0;
   int            m_ptr = 0;

   logic [NUM_REQ-1:0] last_ready, last_rsp_valid;
   logic [DW-1:0]      last_rsp_rdata;
   logic               last_init_done, last_busy, last_ram_ena;

   task automatic tick();
      logic [NUM_REQ-1:0] exp_rdy, exp_rv;
      int n, g, s;
      cmd_rec_t prev, cur;
      @(negedge clk);
      if (rst) begin
         chk("rst_req_ready", 64'(req_ready), 64'(0));
         chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
         chk("rst_init_done", 64'(init_done), 64'(0));
         chk("rst_ram_ena", 64'(ram_ena), 64'(0));
         chk("rst_ram_wea", 64'(ram_wea), 64'(0));
         chk("rst_ram_addra", 64'(ram_addra), 64'(0));
         chk("rst_ram_dina", 64'(ram_dina), 64'(0));
         chk("rst_busy", 64'(busy), 64'(1));
         chk("rst_ram_rsta", 64'(ram_rsta), 64'(1));
         m_cyc = 0;
         m_ptr = 0;
         for (int i = 0; i < 8; i++) begin
            ring[i]    = '{v: 1'b0, we: 1'b0, addr: '0, data: '0};
            rd_ring[i] = 1'b0;
            pend_v[i]  = 1'b0;
         end
      end else begin
         m_cyc++;
         n = m_cyc;
         s = n % 8;
         g = -1;
         if (n > INIT_LEN) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
         end
         exp_rdy = '0;
         if (g >= 0) exp_rdy[g] = 1'b1;
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("init_done", 64'(init_done), 64'(n > INIT_LEN));
         prev = ring[(n + 7) % 8];
         chk("ram_ena", 64'(ram_ena), 64'(prev.v));
         if (prev.v) begin
            chk("ram_wea", 64'(ram_wea), 64'(prev.we));
            chk("ram_addra", 64'(ram_addra), 64'(prev.addr));
            if (prev.we) chk("ram_dina", 64'(ram_dina), 64'(prev.data));
         end
         exp_rv = '0;
         if (pend_v[s]) exp_rv[pend_id[s]] = 1'b1;
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
         if (pend_v[s]) chk("rsp_rdata", 64'(rsp_rdata), 64'(pend_d[s]));
         pend_v[s] = 1'b0;
         chk("busy", 64'(busy), 64'((n <= INIT_LEN) || prev.v || rd_ring[(n + 7) % 8]
                                    || rd_ring[(n + 6) % 8] || rd_ring[(n + 5) % 8]));
         chk("ram_regcea", 64'(ram_regcea), 64'(1));
         chk("ram_rsta", 64'(ram_rsta), 64'(0));
         cur = '{v: 1'b0, we: 1'b0, addr: '0, data: '0};
         if (n <= INIT_LEN) begin
            cur = '{v: 1'b1, we: 1'b1, addr: AW'(n - 1), data: '0};
            shadow[n - 1] = '0;
         end else if (g >= 0) begin
            cur.v    = 1'b1;
            cur.we   = req_we[g];
            cur.addr = req_addr[g*AW +: AW];
            cur.data = req_wdata[g*DW +: DW];
            if (cur.we) begin
               shadow[cur.addr] = cur.data;
            end else begin
               pend_v[(n + 3) % 8]  = 1'b1;
               pend_id[(n + 3) % 8] = g;
               pend_d[(n + 3) % 8]  = shadow[cur.addr];
            end
            m_ptr = (g + 1) % NUM_REQ;
         end
         ring[s]    = cur;
         rd_ring[s] = cur.v && !cur.we;
      end
      last_ready     = req_ready;
      last_rsp_valid = rsp_valid;
      last_rsp_rdata = rsp_rdata;
      last_init_done = init_done;
      last_busy      = busy;
      last_ram_ena   = ram_ena;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [1:0] v, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      req_valid = v;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   task automatic set_rand();
      set_in(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom, $urandom);
   endtask

   typedef struct {
      logic [1:0]    valid;
      logic [1:0]    we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    rdy;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // arbitration vectors, starting from pointer 0
      tbl[0]  = '{2'b11, 2'b00, 6'd1,  6'd2,  32'h0,        32'h0,    2'b01};
      tbl[1]  = '{2'b11, 2'b00, 6'd3,  6'd4,  32'h0,        32'h0,    2'b10};
      tbl[2]  = '{2'b11, 2'b00, 6'd5,  6'd6,  32'h0,        32'h0,    2'b01};
      tbl[3]  = '{2'b11, 2'b00, 6'd7,  6'd8,  32'h0,        32'h0,    2'b10};
      tbl[4]  = '{2'b00, 2'b00, 6'd0,  6'd0,  32'h0,        32'h0,    2'b00};
      tbl[5]  = '{2'b10, 2'b10, 6'd0,  6'd9,  32'h0,        32'h1234, 2'b10};
      tbl[6]  = '{2'b01, 2'b00, 6'd9,  6'd0,  32'h0,        32'h0,    2'b01};
      tbl[7]  = '{2'b00, 2'b00, 6'd0,  6'd0,  32'h0,        32'h0,    2'b00};
      tbl[8]  = '{2'b11, 2'b11, 6'd10, 6'd11, 32'hA,        32'hB,    2'b10};
      tbl[9]  = '{2'b01, 2'b00, 6'd11, 6'd0,  32'h0,        32'h0,    2'b01};
      tbl[10] = '{2'b10, 2'b00, 6'd0,  6'd10, 32'h0,        32'h0,    2'b10};
      tbl[11] = '{2'b11, 2'b00, 6'd9,  6'd9,  32'h0,        32'h0,    2'b01};
      tbl[12] = '{2'b01, 2'b01, 6'd5,  6'd0,  32'hDEADBEEF, 32'h0,    2'b01};
      tbl[13] = '{2'b10, 2'b00, 6'd0,  6'd5,  32'h0,        32'h0,    2'b10};

      // power-on reset
      rst = 1'b1;
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      tick();
      tick();
      rst = 1'b0;

      // zero-fill with requesters pushing (must never be accepted)
      for (int c = 0; c < INIT_LEN; c++) begin
         set_rand();
         tick();
         chk("init_ready", 64'(last_ready), 64'(0));
      end
      chk("init_done_before", 64'(last_init_done), 64'(0));

      // first RUN cycle: both requesters read address 17 after the fill
      set_in(2'b01, 2'b00, 6'd17, 6'd0, '0, '0);
      tick();
      chk("init_done_rise", 64'(last_init_done), 64'(1));
      chk("rd17_grant0", 64'(last_ready), 64'(2'b01));
      set_in(2'b10, 2'b00, 6'd0, 6'd17, '0, '0);
      tick();
      chk("rd17_grant1", 64'(last_ready), 64'(2'b10));
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      tick();
      tick();
      chk("rd17_rsp0_valid", 64'(last_rsp_valid), 64'(2'b01));
      chk("rd17_rsp0_data", 64'(last_rsp_rdata), 64'(0));
      tick();
      chk("rd17_rsp1_valid", 64'(last_rsp_valid), 64'(2'b10));
      chk("rd17_rsp1_data", 64'(last_rsp_rdata), 64'(0));

      // table: contention, idle, writes, read-after-write
      for (int i = 0; i < 14; i++) begin
         set_in(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
         tick();
         chk($sformatf("tbl%0d_ready", i), 64'(last_ready), 64'(tbl[i].rdy));
      end
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      tick();
      tick();
      tick();
      chk("raw_rsp_valid", 64'(last_rsp_valid), 64'(2'b10));
      chk("raw_rsp_data", 64'(last_rsp_rdata), 64'(32'hDEADBEEF));

      // fairness: req1 joins while req0 holds valid with pointer at 0
      set_in(2'b11, 2'b00, 6'd1, 6'd2, '0, '0);
      tick();
      chk("fair_first", 64'(last_ready), 64'(2'b01));
      tick();
      chk("fair_req1_next", 64'(last_ready), 64'(2'b10));

      // idle: no commands, nothing busy, pointer held
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < 6; i++) tick();
      chk("idle_busy", 64'(last_busy), 64'(0));
      chk("idle_ram_ena", 64'(last_ram_ena), 64'(0));
      set_in(2'b11, 2'b00, 6'd3, 6'd4, '0, '0);
      tick();
      chk("idle_ptr_held", 64'(last_ready), 64'(2'b01));

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_rand();
         tick();
      end

      // reset with three reads in flight
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < 4; i++) tick();
      set_in(2'b01, 2'b00, 6'd1, 6'd2, '0, '0);
      tick();
      set_in(2'b10, 2'b00, 6'd1, 6'd2, '0, '0);
      tick();
      set_in(2'b01, 2'b00, 6'd3, 6'd4, '0, '0);
      tick();
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      rst = 1'b1;
      tick();
      chk("midrst_no_rsp", 64'(last_rsp_valid), 64'(0));
      tick();
      chk("midrst_no_rsp2", 64'(last_rsp_valid), 64'(0));
      rst = 1'b0;
      for (int c = 0; c < INIT_LEN; c++) begin
         set_rand();
         tick();
      end
      chk("reinit_done_before", 64'(last_init_done), 64'(0));
      set_in(2'b01, 2'b00, 6'd1, 6'd0, '0, '0);
      tick();
      chk("reinit_done", 64'(last_init_done), 64'(1));
      chk("reinit_ptr0", 64'(last_ready), 64'(2'b01));
      for (int i = 0; i < 60; i++) begin
         set_rand();
         tick();
      end
      set_in(2'b00, 2'b00, '0, '0, '0, '0);
      for (int i = 0; i < 5; i++) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
